// File: rtl/tetris_pkg.sv
// Shared types, shape table and generator constants for the next-piece queue.
// Shape offsets are packed as four {dx+1[1:0], dy[1:0]} nibbles, dot1 in the top nibble.
package tetris_pkg;

  typedef logic [2:0] piece_t;

  localparam logic [15:0] LFSR_MASK       = 16'hB400;
  localparam int unsigned SPAWN_X_DEFAULT = 5;
  localparam logic [15:0] SEED_DEFAULT    = 16'd134;
  localparam logic [6:0]  BAG_FULL        = 7'h7F;

  function automatic logic [15:0] shape_ofs(input piece_t p);
    case (p)
      3'd0:    return 16'h4567;
      3'd1:    return 16'h4859;
      3'd2:    return 16'h4159;
      3'd3:    return 16'h0459;
      3'd4:    return 16'h4815;
      3'd5:    return 16'h8159;
      3'd6:    return 16'h0159;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [9:0] shape_dot(input piece_t p, input int unsigned n,
                                           input int unsigned spawn_x);
    logic [15:0] ofs;
    logic [3:0]  nib;
    logic [4:0]  x;
    ofs = shape_ofs(p);
    nib = ofs[4*(3-n) +: 4];
    x   = 5'(spawn_x) + {3'b000, nib[3:2]} - 5'd1;
    return {x, 3'b000, nib[1:0]};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_MASK : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_nonzero(input logic [15:0] l);
    return (l == 16'h0000) ? 16'h0001 : l;
  endfunction

endpackage

// File: rtl/tetris_piece_gen.sv
// Piece candidate generator: free-running Galois LFSR plus optional 7-bag used-mask.
module tetris_piece_gen
  import tetris_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        mode_in,
  input  logic        push,
  output piece_t      cand,
  output logic        cand_valid
);

  logic [15:0] lfsr_q;
  logic        mode_q;
  logic [6:0]  used_q;
  logic [6:0]  cand_bit;
  logic [6:0]  used_set;
  logic [6:0]  used_next;

  always_comb begin
    cand       = lfsr_q[2:0];
    cand_bit   = 7'(8'd1 << cand);
    cand_valid = (cand != 3'd7) && (!mode_q || ((used_q & cand_bit) == '0));
    used_set   = used_q | cand_bit;
    // The bag refills on the same edge its last piece is drawn.
    used_next  = (used_set == BAG_FULL) ? '0 : used_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= lfsr_nonzero(SEED);
      mode_q <= 1'b0;
      used_q <= '0;
    end else if (seed_load) begin
      lfsr_q <= lfsr_nonzero(seed_in);
      mode_q <= mode_in;
      used_q <= '0;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
      if (push && mode_q) used_q <= used_next;
    end
  end

endmodule

// File: rtl/tetris_next_queue.sv
// Next-piece preview queue: shift-toward-head FIFO fed by tetris_piece_gen,
// with a registered current piece and its spawn cells.
module tetris_next_queue
  import tetris_pkg::*;
#(
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned SPAWN_X = SPAWN_X_DEFAULT,
  parameter logic [15:0] SEED    = SEED_DEFAULT,
  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          take,
  input  logic          seed_load,
  input  logic [15:0]   seed_in,
  input  logic          mode_in,
  input  logic [PW-1:0] peek_sel,
  output logic          ready,
  output logic [3:0]    count,
  output logic [2:0]    peek_index,
  output logic          peek_valid,
  output logic [2:0]    curr_index,
  output logic [9:0]    curr_dot1,
  output logic [9:0]    curr_dot2,
  output logic [9:0]    curr_dot3,
  output logic [9:0]    curr_dot4
);

  typedef enum logic {FILL, FULL} state_t;

  state_t     state_q, state_next;
  piece_t     q_q    [DEPTH];
  piece_t     q_next [DEPTH];
  logic [3:0] count_q, count_next;
  logic [3:0] tail;
  piece_t     cand;
  logic       cand_valid;
  logic       take_ok;
  logic       push;

  tetris_piece_gen #(.SEED(SEED)) u_gen (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .mode_in    (mode_in),
    .push       (push),
    .cand       (cand),
    .cand_valid (cand_valid)
  );

  always_comb begin
    take_ok    = take && !seed_load && (count_q != '0);
    push       = cand_valid && !seed_load && ((state_q == FILL) || take_ok);
    state_next = state_q;
    if (seed_load) begin
      state_next = FILL;
    end else begin
      case (state_q)
        FILL:    if (push && !take_ok && count_q == 4'(DEPTH - 1)) state_next = FULL;
        FULL:    if (take_ok && !push) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  // Shift first, then write the pushed piece at the post-shift tail.
  always_comb begin
    q_next = q_q;
    tail   = count_q;
    if (take_ok) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) q_next[i] = q_q[i+1];
      tail = count_q - 4'd1;
    end
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (4'(i) == tail) q_next[i] = cand;
    end
    if (seed_load)            count_next = '0;
    else if (push && !take_ok) count_next = count_q + 4'd1;
    else if (!push && take_ok) count_next = count_q - 4'd1;
    else                       count_next = count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else begin
      state_q <= state_next;
      count_q <= count_next;
      q_q     <= q_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curr_index <= '0;
      curr_dot1  <= '0;
      curr_dot2  <= '0;
      curr_dot3  <= '0;
      curr_dot4  <= '0;
    end else if (take_ok) begin
      curr_index <= q_q[0];
      curr_dot1  <= shape_dot(q_q[0], 0, SPAWN_X);
      curr_dot2  <= shape_dot(q_q[0], 1, SPAWN_X);
      curr_dot3  <= shape_dot(q_q[0], 2, SPAWN_X);
      curr_dot4  <= shape_dot(q_q[0], 3, SPAWN_X);
    end
  end

  always_comb begin
    ready      = (count_q != '0);
    count      = count_q;
    peek_valid = (4'(peek_sel) < count_q);
    peek_index = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (peek_valid && PW'(i) == peek_sel) peek_index = q_q[i];
  end

endmodule

// File: tb/tb_tetris_next_queue.sv
// Directed bench for tetris_next_queue: per-cycle vector table plus reset, bag and seed sequences.
module tb_tetris_next_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        take = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        mode_in = 1'b0;
  logic [1:0]  peek_sel = '0;
  logic        ready;
  logic [3:0]  count;
  logic [2:0]  peek_index;
  logic        peek_valid;
  logic [2:0]  curr_index;
  logic [9:0]  curr_dot1, curr_dot2, curr_dot3, curr_dot4;

  int tests = 0;
  int fails = 0;

  tetris_next_queue #(.DEPTH(3), .SPAWN_X(5), .SEED(16'd134)) dut (
    .clk        (clk),
    .rst        (rst),
    .take       (take),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .mode_in    (mode_in),
    .peek_sel   (peek_sel),
    .ready      (ready),
    .count      (count),
    .peek_index (peek_index),
    .peek_valid (peek_valid),
    .curr_index (curr_index),
    .curr_dot1  (curr_dot1),
    .curr_dot2  (curr_dot2),
    .curr_dot3  (curr_dot3),
    .curr_dot4  (curr_dot4)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       tk;
    logic       sl;
    logic [15:0] seed;
    logic       mode;
    logic [1:0] psel;
    logic [3:0] cnt;
    logic [2:0] curr;
    logic [2:0] pidx;
    logic       pval;
    logic [9:0] d1, d2, d3, d4;
  } vec_t;

  vec_t vt [12];
  logic [6:0] seen;
  int   waited;

  initial begin
    // Cycle-by-cycle from reset release (SEED 0x0086 draws 6,3,1,0,...),
    // then reseed with 0x0008 (draws 0,4,2,1,0,...).
    vt[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 4'd1, 3'd0, 3'd6, 1'b1, 10'h000, 10'h000, 10'h000, 10'h000};
    vt[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 4'd2, 3'd0, 3'd3, 1'b1, 10'h000, 10'h000, 10'h000, 10'h000};
    vt[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 2'd2, 4'd3, 3'd0, 3'd1, 1'b1, 10'h000, 10'h000, 10'h000, 10'h000};
    vt[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 4'd3, 3'd6, 3'd3, 1'b1, 10'h080, 10'h081, 10'h0A1, 10'h0C1};
    vt[4]  = '{1'b1, 1'b1, 16'h0008, 1'b0, 2'd0, 4'd0, 3'd6, 3'd0, 1'b0, 10'h080, 10'h081, 10'h0A1, 10'h0C1};
    vt[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 4'd1, 3'd6, 3'd0, 1'b1, 10'h080, 10'h081, 10'h0A1, 10'h0C1};
    vt[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 2'd1, 4'd2, 3'd6, 3'd4, 1'b1, 10'h080, 10'h081, 10'h0A1, 10'h0C1};
    vt[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 2'd2, 4'd3, 3'd6, 3'd2, 1'b1, 10'h080, 10'h081, 10'h0A1, 10'h0C1};
    vt[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 4'd3, 3'd0, 3'd4, 1'b1, 10'h0A0, 10'h0A1, 10'h0A2, 10'h0A3};
    vt[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 2'd2, 4'd3, 3'd4, 3'd0, 1'b1, 10'h0A0, 10'h0C0, 10'h081, 10'h0A1};
    vt[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 2'd0, 4'd3, 3'd4, 3'd2, 1'b1, 10'h0A0, 10'h0C0, 10'h081, 10'h0A1};
    vt[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 2'd3, 4'd3, 3'd4, 3'd0, 1'b0, 10'h0A0, 10'h0C0, 10'h081, 10'h0A1};

    #22;
    check("rst_count", count, 4'd0);
    check("rst_ready", ready, 1'b0);
    check("rst_curr", curr_index, 3'd0);
    check("rst_dot1", curr_dot1, 10'h000);
    check("rst_dot4", curr_dot4, 10'h000);
    check("rst_peek_valid", peek_valid, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      take = vt[i].tk; seed_load = vt[i].sl; seed_in = vt[i].seed;
      mode_in = vt[i].mode; peek_sel = vt[i].psel;
      @(posedge clk); #1;
      check($sformatf("v%0d_count", i), count, vt[i].cnt);
      check($sformatf("v%0d_ready", i), ready, (vt[i].cnt != 0));
      check($sformatf("v%0d_curr", i), curr_index, vt[i].curr);
      check($sformatf("v%0d_peek_idx", i), peek_index, vt[i].pidx);
      check($sformatf("v%0d_peek_valid", i), peek_valid, vt[i].pval);
      check($sformatf("v%0d_dots", i), {curr_dot1, curr_dot2, curr_dot3, curr_dot4},
            {vt[i].d1, vt[i].d2, vt[i].d3, vt[i].d4});
      take = 1'b0; seed_load = 1'b0;
      @(negedge clk);
    end

    // Zero seed is replaced by 1, whose first draw is piece 1.
    seed_load = 1'b1; seed_in = 16'h0000; mode_in = 1'b0; peek_sel = 2'd0;
    @(posedge clk); #1;
    seed_load = 1'b0;
    check("zero_seed_lfsr", dut.u_gen.lfsr_q, 16'h0001);
    check("zero_seed_count", count, 4'd0);
    @(posedge clk); #1;
    check("zero_seed_count1", count, 4'd1);
    check("zero_seed_head", peek_index, 3'd1);

    // Asynchronous reset mid-operation discards the queue without a clock edge.
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0; #1;
    check("midrst_count", count, 4'd0);
    check("midrst_ready", ready, 1'b0);
    check("midrst_curr", curr_index, 3'd0);
    check("midrst_dot1", curr_dot1, 10'h000);
    check("midrst_peek_valid", peek_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("refill_count", count, 4'd1);
    check("refill_head", peek_index, 3'd6);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("fill_cnt_le_depth", (count <= 4'd3), 1'b1);
      check("fill_peek_range", (peek_index <= 3'd6), 1'b1);
    end
    check("fill_count_full", count, 4'd3);
    check("fill_ready", ready, 1'b1);

    // Bag mode: the first seven pieces after reseeding are a permutation of 0..6.
    @(negedge clk);
    seed_load = 1'b1; seed_in = 16'hACE1; mode_in = 1'b1;
    @(negedge clk);
    seed_load = 1'b0; mode_in = 1'b0;
    seen = '0;
    for (int k = 0; k < 7; k++) begin
      waited = 0;
      while (!ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      check($sformatf("bag%0d_ready_timeout", k), ready, 1'b1);
      take = 1'b1;
      @(posedge clk); #1;
      take = 1'b0;
      check($sformatf("bag%0d_range", k), (curr_index <= 3'd6), 1'b1);
      if (curr_index <= 3'd6) begin
        check($sformatf("bag%0d_unique", k), seen[curr_index], 1'b0);
        seen[curr_index] = 1'b1;
      end
      @(negedge clk);
    end
    check("bag_permutation", seen, 7'h7F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
